// File: rtl/rice_regfile_ctrl.sv
// rice_regfile_ctrl: busy scoreboard, RAW/WAW issue stall and round-robin writeback arbitration for the 32-entry register file
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_issue_valid/i_issue_inst     decoded instruction from issue; o_issue_ready accepts it
//   i_alu_wb_* / i_lsu_wb_*        writeback requests (valid, rd, data); o_*_wb_ready grants
//   o_rf_we/o_rf_waddr/o_rf_wdata  register-file write port
//   o_busy, o_pending_count        scoreboard bits and their population count
//   o_wb_error                     sticky: writeback granted to a non-busy register
//   RICE_REGFILE_CTRL_BYPASS_EN    registers being written back count as free; adds o_fwd_rs1_hit/o_fwd_rs2_hit
module rice_regfile_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_issue_valid,
    input  logic [31:0]     i_issue_inst,
    output logic            o_issue_ready,
    input  logic            i_alu_wb_valid,
    input  logic [4:0]      i_alu_wb_rd,
    input  logic [XLEN-1:0] i_alu_wb_data,
    output logic            o_alu_wb_ready,
    input  logic            i_lsu_wb_valid,
    input  logic [4:0]      i_lsu_wb_rd,
    input  logic [XLEN-1:0] i_lsu_wb_data,
    output logic            o_lsu_wb_ready,
    output logic            o_rf_we,
    output logic [4:0]      o_rf_waddr,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic [31:0]     o_busy,
`ifdef RICE_REGFILE_CTRL_BYPASS_EN
    output logic            o_fwd_rs1_hit,
    output logic            o_fwd_rs2_hit,
`endif
    output logic [5:0]      o_pending_count,
    output logic            o_wb_error
);
    logic [31:0] r_busy;
    logic [5:0]  r_count;
    logic        r_last_lsu;
    logic        r_wb_error;
    logic [6:0]  w_op;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic        w_is_i, w_is_sb, w_is_uj;
    logic        w_use_rs1, w_use_rs2, w_wr_rd;
    logic [31:0] w_clr, w_kept, w_chk, w_set;
    logic        w_set_en, w_inc, w_dec;
    logic        w_unused;

    assign w_op  = i_issue_inst[6:0];
    assign w_rd  = i_issue_inst[11:7];
    assign w_rs1 = i_issue_inst[19:15];
    assign w_rs2 = i_issue_inst[24:20];
    assign w_unused = ^{i_issue_inst[31:25], i_issue_inst[14:12]};

    // I: load, op-imm, jalr; S/B: store, branch; U/J: lui, auipc, jal; anything else is R
    assign w_is_i  = (w_op == 7'b0000011) || (w_op == 7'b0010011) || (w_op == 7'b1100111);
    assign w_is_sb = (w_op == 7'b0100011) || (w_op == 7'b1100011);
    assign w_is_uj = (w_op == 7'b0110111) || (w_op == 7'b0010111) || (w_op == 7'b1101111);
    assign w_use_rs1 = !w_is_uj;
    assign w_use_rs2 = !(w_is_i || w_is_uj);
    assign w_wr_rd   = !w_is_sb;

    // ALU wins a conflict when LSU won the previous one; lone requesters win outright
    assign o_alu_wb_ready = i_alu_wb_valid && (!i_lsu_wb_valid || r_last_lsu);
    assign o_lsu_wb_ready = i_lsu_wb_valid && !o_alu_wb_ready;
    assign o_rf_waddr = o_alu_wb_ready ? i_alu_wb_rd : i_lsu_wb_rd;
    assign o_rf_wdata = o_alu_wb_ready ? i_alu_wb_data : i_lsu_wb_data;
    assign o_rf_we    = (o_alu_wb_ready || o_lsu_wb_ready) && (o_rf_waddr != 5'd0);

    assign w_clr  = o_rf_we ? (32'd1 << o_rf_waddr) : 32'd0;
    assign w_kept = r_busy & ~w_clr;
`ifdef RICE_REGFILE_CTRL_BYPASS_EN
    assign w_chk = w_kept;
    assign o_fwd_rs1_hit = w_use_rs1 && (w_rs1 != 5'd0) && o_rf_we && (w_rs1 == o_rf_waddr);
    assign o_fwd_rs2_hit = w_use_rs2 && (w_rs2 != 5'd0) && o_rf_we && (w_rs2 == o_rf_waddr);
`else
    assign w_chk = r_busy;
`endif

    // busy[0] is never set, so x0 operands cannot stall
    assign o_issue_ready = !((w_use_rs1 && w_chk[w_rs1]) || (w_use_rs2 && w_chk[w_rs2]) || (w_wr_rd && w_chk[w_rd]));
    assign w_set_en = i_issue_valid && o_issue_ready && w_wr_rd && (w_rd != 5'd0);
    assign w_set    = w_set_en ? (32'd1 << w_rd) : 32'd0;

    // clear-then-set on one busy register nets to zero change
    assign w_inc = w_set_en && !w_kept[w_rd];
    assign w_dec = o_rf_we && r_busy[o_rf_waddr];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_count    <= '0;
            r_last_lsu <= 1'b1;
            r_wb_error <= 1'b0;
        end else begin
            r_busy  <= w_kept | w_set;
            r_count <= r_count + 6'(w_inc) - 6'(w_dec);
            if (i_alu_wb_valid && i_lsu_wb_valid)
                r_last_lsu <= o_lsu_wb_ready;
            if (o_rf_we && !r_busy[o_rf_waddr])
                r_wb_error <= 1'b1;
        end
    end

    assign o_busy          = r_busy;
    assign o_pending_count = r_count;
    assign o_wb_error      = r_wb_error;
endmodule

// File: tb/tb_rice_regfile_ctrl.sv
// tb_rice_regfile_ctrl: directed and randomized checks of rice_regfile_ctrl against a register-level scoreboard model
module tb_rice_regfile_ctrl;
    logic        clk = 1'b0;
    logic        i_rst = 1'b0, i_issue_valid = 1'b0;
    logic [31:0] i_issue_inst = '0;
    logic        i_alu_wb_valid = 1'b0, i_lsu_wb_valid = 1'b0;
    logic [4:0]  i_alu_wb_rd = '0, i_lsu_wb_rd = '0;
    logic [31:0] i_alu_wb_data = '0, i_lsu_wb_data = '0;
    logic        o_issue_ready, o_alu_wb_ready, o_lsu_wb_ready, o_rf_we, o_wb_error;
    logic [4:0]  o_rf_waddr;
    logic [31:0] o_rf_wdata, o_busy;
    logic [5:0]  o_pending_count;

    int tests = 0;
    int fails = 0;
    bit mbusy[32];
    bit merr = 0;
    bit mlast_lsu = 1;

    always #5 clk = ~clk;

    rice_regfile_ctrl #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_issue_valid(i_issue_valid), .i_issue_inst(i_issue_inst), .o_issue_ready(o_issue_ready),
        .i_alu_wb_valid(i_alu_wb_valid), .i_alu_wb_rd(i_alu_wb_rd), .i_alu_wb_data(i_alu_wb_data),
        .o_alu_wb_ready(o_alu_wb_ready),
        .i_lsu_wb_valid(i_lsu_wb_valid), .i_lsu_wb_rd(i_lsu_wb_rd), .i_lsu_wb_data(i_lsu_wb_data),
        .o_lsu_wb_ready(o_lsu_wb_ready),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_busy(o_busy), .o_pending_count(o_pending_count), .o_wb_error(o_wb_error)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_ins(input int rd, input int rs1);
        return {12'h001, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] r_ins(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] s_ins(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] u_ins(input int rd);
        return {20'h12345, 5'(rd), 7'b0110111};
    endfunction

    function automatic void uses(input logic [31:0] inst, output bit u1, output bit u2, output bit w);
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1; u2 = 0; w = 1; end
            7'b0100011, 7'b1100011:             begin u1 = 1; u2 = 1; w = 0; end
            7'b0110111, 7'b0010111, 7'b1101111: begin u1 = 0; u2 = 0; w = 1; end
            default:                            begin u1 = 1; u2 = 1; w = 1; end
        endcase
    endfunction

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic logic [31:0] mvec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic step(input logic rst, input logic iv, input logic [31:0] inst,
                        input logic av, input logic [4:0] ar, input logic [31:0] adt,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ldt,
                        output logic ga, output logic gl);
        bit u1, u2, w;
        logic er, we;
        logic [4:0] wa, rs1, rs2, rd;
        logic [31:0] wd;
        @(negedge clk);
        i_rst = rst; i_issue_valid = iv; i_issue_inst = inst;
        i_alu_wb_valid = av; i_alu_wb_rd = ar; i_alu_wb_data = adt;
        i_lsu_wb_valid = lv; i_lsu_wb_rd = lr; i_lsu_wb_data = ldt;
        #1;
        uses(inst, u1, u2, w);
        rs1 = inst[19:15]; rs2 = inst[24:20]; rd = inst[11:7];
        er = !((u1 && rs1 != 0 && mbusy[rs1]) || (u2 && rs2 != 0 && mbusy[rs2]) || (w && rd != 0 && mbusy[rd]));
        if (av && lv) begin ga = mlast_lsu; gl = !mlast_lsu; end
        else begin ga = av; gl = lv; end
        wa = ga ? ar : lr;
        wd = ga ? adt : ldt;
        we = (ga || gl) && wa != 0;
        chk("issue_ready", o_issue_ready, er);
        chk("alu_ready", o_alu_wb_ready, ga);
        chk("lsu_ready", o_lsu_wb_ready, gl);
        chk("rf_we", o_rf_we, we);
        if (ga || gl) begin
            chk("rf_waddr", o_rf_waddr, wa);
            chk("rf_wdata", o_rf_wdata, wd);
        end
        chk("busy", o_busy, mvec());
        chk("pending_count", o_pending_count, mcount());
        chk("wb_error", o_wb_error, merr);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            merr = 0;
            mlast_lsu = 1;
        end else begin
            if (av && lv) mlast_lsu = gl;
            if (we) begin
                if (!mbusy[wa]) merr = 1;
                mbusy[wa] = 0;
            end
            if (iv && er && w && rd != 0) mbusy[rd] = 1;
        end
    endtask

    task automatic issue(input logic [31:0] inst);
        logic a, b;
        step(0, 1, inst, 0, 0, 0, 0, 0, 0, a, b);
    endtask
    task automatic alu_wb(input logic [4:0] rd, input logic [31:0] d);
        logic a, b;
        step(0, 0, 0, 1, rd, d, 0, 0, 0, a, b);
    endtask
    task automatic lsu_wb(input logic [4:0] rd, input logic [31:0] d);
        logic a, b;
        step(0, 0, 0, 0, 0, 0, 1, rd, d, a, b);
    endtask
    task automatic both_wb(input logic [4:0] ar, input logic [4:0] lr);
        logic a, b;
        step(0, 0, 0, 1, ar, 32'hA000_0000 | 32'(ar), 1, lr, 32'hB000_0000 | 32'(lr), a, b);
    endtask
    task automatic reset_cycle();
        logic a, b;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask
    task automatic idle();
        logic a, b;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b);
    endtask

    function automatic logic [4:0] pick(input int excl);
        int q[$];
        for (int i = 1; i < 32; i++) if (mbusy[i] && i != excl) q.push_back(i);
        if (q.size() == 0 || $urandom_range(9) == 0) return 5'd0;
        return 5'(q[$urandom_range(q.size() - 1)]);
    endfunction

    initial begin
        logic [6:0]  ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111};
        logic        ap, lp, ga, gl, iv;
        logic [4:0]  ar, lr;
        logic [31:0] ad, ld, inst;
        ap = 0; lp = 0; ar = 0; lr = 0; ad = 0; ld = 0;

        reset_cycle();
        reset_cycle();
        idle();
        issue(i_ins(5, 0));
        #1 chk("busy5_after_addi", o_busy[5], 1'b1);
        chk("count_after_addi", o_pending_count, 6'd1);
        issue(r_ins(6, 5, 1));
        step(0, 1, r_ins(6, 5, 1), 1, 5, 32'hDEAD_0005, 0, 0, 0, ga, gl);
        issue(r_ins(6, 5, 1));

        issue(i_ins(3, 0));
        issue(i_ins(4, 0));
        issue(i_ins(7, 0));
        issue(i_ins(8, 0));
        both_wb(3, 4);
        both_wb(7, 4);
        both_wb(7, 8);
        lsu_wb(8, 32'h0000_0808);

        issue(u_ins(0));
        issue(s_ins(2, 5));
        issue(i_ins(2, 0));
        issue(s_ins(2, 5));
        lsu_wb(2, 32'h2222_2222);
        issue(s_ins(2, 5));
        alu_wb(6, 32'h6666_6666);
        alu_wb(0, 32'h0);
        idle();

        reset_cycle();
        repeat (400) begin
            if (!ap && $urandom_range(2) == 0) begin
                ar = pick(lp ? int'(lr) : -1);
                ad = $urandom();
                ap = 1;
            end
            if (!lp && $urandom_range(2) == 0) begin
                lr = pick(ap ? int'(ar) : -1);
                ld = $urandom();
                lp = 1;
            end
            iv = ($urandom_range(3) != 0);
            inst = $urandom();
            inst[6:0] = ops[$urandom_range(9)];
            step(0, iv, inst, ap, ar, ad, lp, lr, ld, ga, gl);
            if (ga) ap = 0;
            if (gl) lp = 0;
        end
        for (int k = 0; k < 4 && (ap || lp); k++) begin
            step(0, 0, 0, ap, ar, ad, lp, lr, ld, ga, gl);
            if (ga) ap = 0;
            if (gl) lp = 0;
        end
        chk("drained", {30'd0, ap, lp}, 32'd0);

        reset_cycle();
        alu_wb(9, 32'h0909_0909);
        #1 chk("wb_error_set", o_wb_error, 1'b1);
        idle();
        issue(i_ins(9, 0));
        idle();

        reset_cycle();
        for (int i = 1; i < 32; i++) issue(i_ins(i, 0));
        #1 chk("fill_count", o_pending_count, 6'd31);
        chk("fill_busy", o_busy, 32'hFFFF_FFFE);
        idle();
        reset_cycle();
        #1 chk("reset_busy", o_busy, 32'd0);
        chk("reset_count", o_pending_count, 6'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
